// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator cursor controller.
// Grid size defaults, FSM state and direction enums, key index helper.
package calc_pkg;

  localparam int COLS_DEF = 6;
  localparam int ROWS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    REPEAT,
    KEY_WAIT,
    KEY_REL
  } cursor_state_t;

  typedef enum {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  function automatic logic [4:0] key_index(
    input logic [2:0] x,
    input logic [1:0] y,
    input int         cols = COLS_DEF
  );
    return 5'(int'(y) * cols + int'(x));
  endfunction

endpackage

// File: rtl/cursor_repeat_timer.sv
// Hold timer for direction auto-repeat: clear, count, terminal pulse.
// Ports: clk, rst, clr, en, sel_rate (0=initial delay, 1=repeat), tc.
module cursor_repeat_timer #(
  parameter int DELAY = 12_500_000,
  parameter int RATE  = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel_rate,
  output logic tc
);

  localparam int MAXV = (DELAY > RATE) ? DELAY : RATE;
  localparam int W    = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [W-1:0] D_LAST = W'(DELAY - 1);
  localparam logic [W-1:0] R_LAST = W'(RATE - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == (sel_rate ? R_LAST : D_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/calc_cursor_ctrl.sv
// Calculator cursor over the key grid: moves, auto-repeat, key entry.
// In: clk rst btn_* matrix_x/y grid_en key_ack. Out: cursor_x/y highlight key_valid key_code.
module calc_cursor_ctrl
  import calc_pkg::*;
#(
  parameter int COLS         = COLS_DEF,
  parameter int ROWS         = ROWS_DEF,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_enter,
  input  logic [2:0] matrix_x,
  input  logic [1:0] matrix_y,
  input  logic       grid_en,
  input  logic       key_ack,
  output logic [2:0] cursor_x,
  output logic [1:0] cursor_y,
  output logic       highlight,
  output logic       key_valid,
  output logic [4:0] key_code
);

  localparam int B_ENT = 0;
  localparam int B_UP  = 1;
  localparam int B_DN  = 2;
  localparam int B_LT  = 3;
  localparam int B_RT  = 4;

  localparam logic [2:0] X_MAX = 3'(COLS - 1);
  localparam logic [1:0] Y_MAX = 2'(ROWS - 1);

  cursor_state_t state, state_nx;
  dir_t          lat_dir, mv_dir;

  logic [4:0] btn, btn_q, pr;
  logic       held, tc;
  logic       do_move, lat_load;
  logic       tmr_clr, tmr_en;
  logic       key_cap, key_clr;
  logic [2:0] nx;
  logic [1:0] ny;

  assign btn = {btn_right, btn_left, btn_down, btn_up, btn_enter};
  assign pr  = btn & ~btn_q;

  always_comb begin
    held = 1'b0;
    unique case (lat_dir)
      DIR_UP:    held = btn_up;
      DIR_DOWN:  held = btn_down;
      DIR_LEFT:  held = btn_left;
      DIR_RIGHT: held = btn_right;
      default:   held = 1'b0;
    endcase
  end

  cursor_repeat_timer #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .sel_rate (state == REPEAT),
    .tc       (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (key_cap)       state_nx = KEY_WAIT;
        else if (lat_load) state_nx = DELAY;
      end
      DELAY: begin
        if (!held)        state_nx = IDLE;
        else if (do_move) state_nx = REPEAT;
      end
      REPEAT: begin
        if (!held) state_nx = IDLE;
      end
      KEY_WAIT: begin
        if (key_clr) state_nx = KEY_REL;
      end
      KEY_REL: begin
        if (!btn_enter) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only the first press in priority order acts; the rest are dropped.
  always_comb begin
    do_move  = 1'b0;
    mv_dir   = lat_dir;
    lat_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    key_cap  = 1'b0;
    key_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        priority case (1'b1)
          pr[B_ENT]: key_cap = 1'b1;
          pr[B_UP]: begin
            do_move = 1'b1;
            mv_dir  = DIR_UP;
          end
          pr[B_DN]: begin
            do_move = 1'b1;
            mv_dir  = DIR_DOWN;
          end
          pr[B_LT]: begin
            do_move = 1'b1;
            mv_dir  = DIR_LEFT;
          end
          pr[B_RT]: begin
            do_move = 1'b1;
            mv_dir  = DIR_RIGHT;
          end
          default: ;
        endcase
        lat_load = do_move;
        tmr_clr  = do_move;
      end
      DELAY, REPEAT: begin
        if (held) begin
          if (tc) begin
            do_move = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      KEY_WAIT: key_clr = key_ack;
      default: ;
    endcase
  end

  always_comb begin
    nx = cursor_x;
    ny = cursor_y;
    if (do_move) begin
      unique case (mv_dir)
        DIR_UP:    ny = (cursor_y == 2'd0) ? Y_MAX : cursor_y - 2'd1;
        DIR_DOWN:  ny = (cursor_y == Y_MAX) ? 2'd0 : cursor_y + 2'd1;
        DIR_LEFT:  nx = (cursor_x == 3'd0) ? X_MAX : cursor_x - 3'd1;
        DIR_RIGHT: nx = (cursor_x == X_MAX) ? 3'd0 : cursor_x + 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q     <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
      lat_dir   <= DIR_UP;
      key_valid <= 1'b0;
      key_code  <= '0;
      highlight <= 1'b0;
    end else begin
      btn_q     <= btn;
      cursor_x  <= nx;
      cursor_y  <= ny;
      highlight <= grid_en &&
                   (matrix_x == cursor_x) &&
                   (matrix_y == cursor_y);
      if (lat_load) lat_dir <= mv_dir;
      if (key_cap) begin
        key_valid <= 1'b1;
        key_code  <= key_index(cursor_x, cursor_y, COLS);
      end else if (key_clr) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_cursor_ctrl.sv
// Self-checking bench for calc_cursor_ctrl with short repeat timings.
// Count-based reference model plus directed literal checks.
module tb_calc_cursor_ctrl;

  localparam int TD = 8;
  localparam int TR = 3;

  logic       clk, rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_enter;
  logic [2:0] matrix_x;
  logic [1:0] matrix_y;
  logic       grid_en, key_ack;
  logic [2:0] cursor_x;
  logic [1:0] cursor_y;
  logic       highlight, key_valid;
  logic [4:0] key_code;

  int total = 0;
  int bad   = 0;

  calc_cursor_ctrl #(
    .COLS         (6),
    .ROWS         (4),
    .REPEAT_DELAY (TD),
    .REPEAT_RATE  (TR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_enter (btn_enter),
    .matrix_x  (matrix_x),
    .matrix_y  (matrix_y),
    .grid_en   (grid_en),
    .key_ack   (key_ack),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .highlight (highlight),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: button index 0=enter 1=up 2=down 3=left 4=right,
  // lower index wins. mode 0=free 1=holding 2=key pending 3=await release.
  logic [4:0] mb, m_prev, m_e;
  int m_x, m_y, m_kc, m_mode, m_dir, m_n;
  bit m_kv, m_hl;

  assign mb = {btn_right, btn_left, btn_down, btn_up, btn_enter};

  task automatic step(input int d);
    case (d)
      1: m_y = (m_y + 3) % 4;
      2: m_y = (m_y + 1) % 4;
      3: m_x = (m_x + 5) % 6;
      4: m_x = (m_x + 1) % 6;
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_x = 0; m_y = 0; m_kc = 0; m_kv = 0; m_hl = 0;
        m_mode = 0; m_dir = 1; m_n = 0; m_prev = '0;
      end else begin
        m_hl = grid_en && (int'(matrix_x) == m_x) &&
               (int'(matrix_y) == m_y);
        m_e = mb & ~m_prev;
        case (m_mode)
          0: begin
            if (m_e[0]) begin
              m_kc = m_y * 6 + m_x;
              m_kv = 1;
              m_mode = 2;
            end else begin
              for (int d = 1; d <= 4; d++) begin
                if (m_e[d] && m_mode == 0) begin
                  step(d);
                  m_dir = d;
                  m_n = 1;
                  m_mode = 1;
                end
              end
            end
          end
          1: begin
            if (!mb[m_dir]) m_mode = 0;
            else begin
              m_n++;
              if (m_n - 1 >= TD && (m_n - 1 - TD) % TR == 0)
                step(m_dir);
            end
          end
          2: if (key_ack) begin m_kv = 0; m_mode = 3; end
          3: if (!mb[0]) m_mode = 0;
          default: ;
        endcase
        m_prev = mb;
      end
    end
  end

  always @(negedge clk) begin
    chk("cur_x", int'(cursor_x), m_x);
    chk("cur_y", int'(cursor_y), m_y);
    chk("hl", int'(highlight), int'(m_hl));
    chk("kvalid", int'(key_valid), int'(m_kv));
    chk("kcode", int'(key_code), m_kc);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int b);
    case (b)
      1: btn_up = 1;
      2: btn_down = 1;
      3: btn_left = 1;
      4: btn_right = 1;
      default: btn_enter = 1;
    endcase
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_enter = 0;
    tick();
  endtask

  int moves[$];
  int py;
  int exp_mv[5] = '{1, 9, 12, 15, 18};

  initial begin
    rst = 1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_enter = 0;
    matrix_x = 0; matrix_y = 0; grid_en = 0; key_ack = 0;
    tick(2);
    chk("rst_x", int'(cursor_x), 0);
    chk("rst_kv", int'(key_valid), 0);
    chk("rst_kc", int'(key_code), 0);
    chk("rst_hl", int'(highlight), 0);
    rst = 0;
    tick();

    btn_right = 1;
    tick();
    chk("t1_x1", int'(cursor_x), 1);
    chk("t1_y0", int'(cursor_y), 0);
    btn_right = 0;
    tick();
    for (int i = 0; i < 5; i++) pulse(4);
    chk("t1_wrap", int'(cursor_x), 0);

    pulse(1);
    chk("t2_up", int'(cursor_y), 3);
    pulse(3);
    chk("t2_left", int'(cursor_x), 5);

    py = int'(cursor_y);
    btn_down = 1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (int'(cursor_y) != py) moves.push_back(i);
      py = int'(cursor_y);
      if (i == 20) btn_down = 0;
    end
    chk("t3_nmoves", moves.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t3_mv_at", (i < moves.size()) ? moves[i] : -1, exp_mv[i]);
    chk("t3_y", int'(cursor_y), 0);
    chk("t3_x", int'(cursor_x), 5);

    pulse(3);
    pulse(2);
    pulse(2);
    btn_enter = 1;
    tick();
    chk("t4_kv", int'(key_valid), 1);
    chk("t4_kc", int'(key_code), 16);
    tick(10);
    chk("t4_kv_hold", int'(key_valid), 1);
    chk("t4_kc_hold", int'(key_code), 16);
    key_ack = 1;
    tick();
    key_ack = 0;
    chk("t4_ack", int'(key_valid), 0);
    tick(4);
    chk("t4_no_rpt", int'(key_valid), 0);
    btn_enter = 0;
    tick();
    btn_enter = 1;
    tick();
    chk("t4_again", int'(key_valid), 1);
    btn_enter = 0;
    key_ack = 1;
    tick();
    key_ack = 0;
    tick(2);

    btn_enter = 1;
    btn_right = 1;
    tick();
    chk("t5_kv", int'(key_valid), 1);
    chk("t5_x", int'(cursor_x), 4);
    chk("t5_kc", int'(key_code), 16);
    #2 rst = 1;
    #1;
    chk("t5_rst_kv", int'(key_valid), 0);
    chk("t5_rst_x", int'(cursor_x), 0);
    chk("t5_rst_y", int'(cursor_y), 0);
    tick();
    btn_enter = 0;
    btn_right = 0;
    tick();
    rst = 0;
    tick();

    pulse(4);
    pulse(4);
    pulse(2);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 6; x++) begin
        matrix_x = 3'(x);
        matrix_y = 2'(y);
        grid_en = 1;
        tick();
        chk("t6_hl", int'(highlight), (x == 2 && y == 1) ? 1 : 0);
      end
    end
    matrix_x = 2;
    matrix_y = 1;
    grid_en = 0;
    tick();
    chk("t6_gen0", int'(highlight), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
